// File: rtl/hilo_mdu.sv
// hilo_mdu: multi-cycle multiply/divide unit holding the architectural HI/LO
// pair. Results are computed at start into shadow registers and committed
// when the busy down-counter expires, so mfhi/mflo never see in-flight data.
module hilo_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  HILOOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  input  logic        D_isHILO,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HILO_out,
  output logic        stall_hilo
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  logic [31:0] r_hi, r_lo, r_shi, r_slo;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_divzero;

  logic [3:0]  w_cnt_nxt;
  logic        w_is_md, w_is_div, w_commit, w_mt_ok;
  logic [63:0] w_prod_s, w_prod_u;
  logic [31:0] w_bd, w_am, w_bm, w_qm, w_rm, w_qs, w_rs, w_qu, w_ru;
  logic [31:0] w_res_hi, w_res_lo;

  assign w_is_md  = (HILOOp >= OP_MULT) && (HILOOp <= OP_DIVU);
  assign w_is_div = (HILOOp == OP_DIV) || (HILOOp == OP_DIVU);
  assign w_commit = (r_cnt == 4'd1);
  assign w_mt_ok  = !Req && !r_busy;

  // Arithmetic: products over sign/zero-extended operands; signed divide via
  // magnitudes so that 0x80000000 / -1 wraps to 0x80000000 with remainder 0.
  // A zero divisor is swapped for 1 only to keep the datapath defined; the
  // result is discarded at commit by the latched divzero flag.
  always_comb begin
    w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    w_prod_u = {32'd0, A} * {32'd0, B};
    w_bd     = (B == 32'd0) ? 32'd1 : B;
    w_am     = A[31] ? (32'd0 - A) : A;
    w_bm     = w_bd[31] ? (32'd0 - w_bd) : w_bd;
    w_qm     = w_am / w_bm;
    w_rm     = w_am % w_bm;
    w_qs     = (A[31] ^ w_bd[31]) ? (32'd0 - w_qm) : w_qm;
    w_rs     = A[31] ? (32'd0 - w_rm) : w_rm;
    w_qu     = A / w_bd;
    w_ru     = A % w_bd;
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (HILOOp)
      OP_MULT:  begin w_res_hi = w_prod_s[63:32]; w_res_lo = w_prod_s[31:0]; end
      OP_MULTU: begin w_res_hi = w_prod_u[63:32]; w_res_lo = w_prod_u[31:0]; end
      OP_DIV:   begin w_res_hi = w_rs;            w_res_lo = w_qs;           end
      OP_DIVU:  begin w_res_hi = w_ru;            w_res_lo = w_qu;           end
      default:  ;
    endcase
  end

  // State register: busy down-counter plus its registered nonzero flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= 4'd0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != 4'd0);
    end
  end

  // Next-state: load on start, count down while busy, hold in idle
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_cnt != 4'd0)
      w_cnt_nxt = r_cnt - 4'd1;
    else if (Start)
      w_cnt_nxt = w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  end

  // Outputs: start gating, stall request and the mfhi/mflo read mux
  always_comb begin
    Busy       = r_busy;
    Start      = w_is_md && !Req && !r_busy;
    stall_hilo = D_isHILO && (Start || r_busy);
    case (HILOOp)
      OP_MFHI: HILO_out = r_hi;
      OP_MFLO: HILO_out = r_lo;
      default: HILO_out = 32'd0;
    endcase
  end

  // Shadow result capture at start, divzero latch
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shi     <= 32'd0;
      r_slo     <= 32'd0;
      r_divzero <= 1'b0;
    end else if (Start) begin
      r_shi     <= w_res_hi;
      r_slo     <= w_res_lo;
      r_divzero <= w_is_div && (B == 32'd0);
    end
  end

  // Architectural HI/LO: commit on counter expiry, mt writes only when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (w_commit) begin
      if (!r_divzero) begin
        r_hi <= r_shi;
        r_lo <= r_slo;
      end
    end else if (w_mt_ok) begin
      if (HILOOp == OP_MTHI) r_hi <= A;
      if (HILOOp == OP_MTLO) r_lo <= A;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu: directed scenarios plus random traffic, checked every cycle
// against a timeline model (start cycle / end cycle, 64-bit arithmetic).
module tb_hilo_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  HILOOp;
  logic [31:0] A, B;
  logic        Req, D_isHILO;
  logic        Start, Busy, stall_hilo;
  logic [31:0] HILO_out;

  int n_chk = 0;
  int n_err = 0;

  // model state
  int          cyc;
  int          m_start, m_end;
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  bit          m_dz;

  hilo_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .HILOOp(HILOOp), .A(A), .B(B), .Req(Req),
    .D_isHILO(D_isHILO), .Start(Start), .Busy(Busy), .HILO_out(HILO_out),
    .stall_hilo(stall_hilo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_busy();
    return (cyc > m_start) && (cyc <= m_end);
  endfunction

  // One clock: drive, check combinational/registered outputs mid-cycle,
  // then advance the model across the rising edge.
  task automatic cycle(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic req, input logic dis, input logic rst,
                       input bit cen = 0, input logic [31:0] cexp = 32'd0);
    bit          bz, st;
    logic [31:0] exp_out;
    longint      sa, sb, q, r;
    logic [63:0] p;
    HILOOp = op; A = a; B = b; Req = req; D_isHILO = dis; reset = rst;
    #4;
    bz = m_busy();
    st = (op >= 1) && (op <= 4) && !req && !bz;
    exp_out = (op == 5) ? m_hi : (op == 6) ? m_lo : 32'd0;
    chk("busy",  {63'd0, Busy},       {63'd0, bz});
    chk("start", {63'd0, Start},      {63'd0, st});
    chk("stall", {63'd0, stall_hilo}, {63'd0, dis && (st || bz)});
    chk("hilo",  {32'd0, HILO_out},   {32'd0, exp_out});
    if (cen) chk("const", {32'd0, HILO_out}, {32'd0, cexp});
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_dz = 0; m_start = cyc; m_end = cyc;
    end else begin
      if (bz && cyc == m_end && !m_dz) begin m_hi = m_ph; m_lo = m_pl; end
      if (st) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        m_dz = 0;
        case (op)
          5'd1: begin p = 64'(sa * sb); {m_ph, m_pl} = p; end
          5'd2: begin p = {32'd0, a} * {32'd0, b}; {m_ph, m_pl} = p; end
          5'd3: begin
            m_dz = (b == 0);
            if (!m_dz) begin q = sa / sb; r = sa % sb; m_pl = q[31:0]; m_ph = r[31:0]; end
          end
          default: begin
            m_dz = (b == 0);
            if (!m_dz) begin m_pl = a / b; m_ph = a % b; end
          end
        endcase
        m_start = cyc;
        m_end   = cyc + ((op >= 3) ? 10 : 5);
      end else if (!req && !bz) begin
        if (op == 7) m_hi = a;
        if (op == 8) m_lo = a;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n, input logic dis);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, dis, 0);
  endtask

  initial begin
    logic [4:0]  op;
    logic [31:0] ra, rb;
    cyc = 0; m_start = 0; m_end = 0;
    m_hi = 0; m_lo = 0; m_ph = 0; m_pl = 0; m_dz = 0;
    HILOOp = 0; A = 0; B = 0; Req = 0; D_isHILO = 0; reset = 1;
    repeat (2) @(posedge clk);
    #1;
    // reset state (with reset still asserted), then release
    cycle(5, 0, 0, 0, 1, 1, 1, 32'd0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'd0);

    // mult -2*3, stall visible T..T+5 with D_isHILO=1
    cycle(1, 32'hFFFFFFFE, 3, 0, 1, 0);
    idle(5, 1);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFA);
    // multu with D_isHILO=0: stall never rises
    cycle(2, 32'hFFFFFFFE, 3, 0, 0, 0);
    idle(5, 0);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'h00000002);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFA);
    // div -7/2 then divu 7/2
    cycle(3, 32'hFFFFFFF9, 2, 0, 0, 0);
    idle(10, 0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFD);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'hFFFFFFFF);
    cycle(4, 7, 2, 0, 0, 0);
    idle(10, 0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'd3);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'd1);
    // overflow divide
    cycle(3, 32'h80000000, 32'hFFFFFFFF, 0, 0, 0);
    idle(10, 0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'h80000000);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'd0);
    // mthi then divu by zero: HI/LO untouched
    cycle(7, 32'h1234, 0, 0, 0, 0);
    cycle(8, 32'h55AA, 0, 0, 0, 0);
    cycle(4, 5, 0, 0, 1, 0);
    idle(10, 1);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'h1234);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'h55AA);
    // Req suppresses start and mt
    cycle(1, 32'd9, 32'd9, 1, 1, 0);
    cycle(7, 32'hDEAD, 0, 1, 0, 0);
    cycle(5, 0, 0, 0, 0, 0, 1, 32'h1234);
    // start/mt attempts while busy are ignored
    cycle(2, 32'd4, 32'd4, 0, 0, 0);
    cycle(1, 32'd100, 32'd100, 0, 0, 0);
    cycle(7, 32'hBEEF, 0, 0, 0, 0);
    idle(3, 0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'd16);
    // reset at T+3 of a div
    cycle(3, 32'd100, 32'd7, 0, 0, 0);
    idle(2, 0);
    cycle(0, 0, 0, 0, 0, 1);
    cycle(5, 0, 0, 0, 1, 0, 1, 32'd0);
    idle(10, 0);
    cycle(6, 0, 0, 0, 0, 0, 1, 32'd0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      op = 5'($urandom_range(0, 10));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
      cycle(op, ra, rb, ($urandom_range(0, 7) == 0), 1'($urandom),
            ($urandom_range(0, 99) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
